// File: rtl/mult_pkg.sv
// Shared types for the sequential shift-and-add multiplier.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of add/shift iterations for a multiplier magnitude: its bit length.
  function automatic int unsigned iterCount(input logic [63:0] mag);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 64; i++) begin
      if (mag[i]) n = 32'(i + 1);
    end
    return n;
  endfunction

endpackage

// File: rtl/shift_add_datapath.sv
// Operand/partial-product registers with add/shift/negate logic,
// sequenced by load/step/finish strobes from the controller.
module shift_add_datapath #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_i,
  input  logic               step_i,
  input  logic               finish_i,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               b_zero_o,
  output logic               count_zero_o,
  output logic [2*WIDTH-1:0] r_o
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2*WIDTH-1:0] p_q, p_d;
  logic [CW-1:0]      count_q, count_d;
  logic               neg_q, neg_d;
  logic [2*WIDTH-1:0] r_q, r_d;

  logic [WIDTH-1:0]   aMag;
  logic [WIDTH-1:0]   bMag;

  // The most negative operand negates to 2^(WIDTH-1), which still fits unsigned.
  assign aMag = (signed_i && a_i[WIDTH-1]) ? -a_i : a_i;
  assign bMag = (signed_i && b_i[WIDTH-1]) ? -b_i : b_i;

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    p_d     = p_q;
    count_d = count_q;
    neg_d   = neg_q;
    r_d     = r_q;
    if (load_i) begin
      a_d     = {{WIDTH{1'b0}}, aMag};
      b_d     = bMag;
      p_d     = '0;
      count_d = CW'(WIDTH);
      neg_d   = signed_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
    end else if (step_i) begin
      p_d     = p_q + (b_q[0] ? a_q : '0);
      a_d     = a_q << 1;
      b_d     = b_q >> 1;
      count_d = count_q - CW'(1);
    end
    if (finish_i) begin
      r_d = neg_q ? -p_q : p_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q     <= '0;
      b_q     <= '0;
      p_q     <= '0;
      count_q <= '0;
      neg_q   <= 1'b0;
      r_q     <= '0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      p_q     <= p_d;
      count_q <= count_d;
      neg_q   <= neg_d;
      r_q     <= r_d;
    end
  end

  assign b_zero_o     = (b_q == '0);
  assign count_zero_o = (count_q == '0);
  assign r_o          = r_q;

endmodule

// File: rtl/shift_add_multiplier.sv
// Self-sequenced shift-and-add multiplier with early termination and
// valid/ready handshakes; signed or unsigned per operation.
module shift_add_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] r_out,
  output logic               busy
);

  state_t state_q, state_d;
  logic   valid_q, valid_d;
  logic   load, step, finish;
  logic   bZero, countZero;
  logic   signedEff;

  assign signedEff = signed_mode & SIGNED_EN;

  shift_add_datapath #(
    .WIDTH(WIDTH)
  ) u_datapath (
    .clk         (clk),
    .reset       (reset),
    .load_i      (load),
    .step_i      (step),
    .finish_i    (finish),
    .signed_i    (signedEff),
    .a_i         (a_in),
    .b_i         (b_in),
    .b_zero_o    (bZero),
    .count_zero_o(countZero),
    .r_o         (r_out)
  );

  // The first DONE cycle forms the signed result; out_valid rises with it.
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    load    = 1'b0;
    step    = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (bZero || countZero) begin
          state_d = DONE;
        end else begin
          step = 1'b1;
        end
      end
      DONE: begin
        if (!valid_q) begin
          finish  = 1'b1;
          valid_d = 1'b1;
        end else if (out_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == RUN) || (state_q == DONE);
  assign out_valid = valid_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Scoreboard bench: stimulus queues model results, a monitor checks
// every product and its latency when out_valid rises.
module tb_shift_add_multiplier;
  import mult_pkg::*;

  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic         inValid, inReady, signedMode, outValid, outReady, busy;
  logic [W-1:0] aIn, bIn;
  logic [2*W-1:0] rOut;

  logic         inValidU, inReadyU, signedModeU, outValidU, outReadyU, busyU;
  logic [W-1:0] aInU, bInU;
  logic [2*W-1:0] rOutU;

  shift_add_multiplier #(.WIDTH(W), .SIGNED_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .in_valid(inValid), .in_ready(inReady),
    .signed_mode(signedMode), .a_in(aIn), .b_in(bIn), .out_valid(outValid),
    .out_ready(outReady), .r_out(rOut), .busy(busy)
  );

  shift_add_multiplier #(.WIDTH(W), .SIGNED_EN(1'b0)) dutU (
    .clk(clk), .reset(reset), .in_valid(inValidU), .in_ready(inReadyU),
    .signed_mode(signedModeU), .a_in(aInU), .b_in(bInU), .out_valid(outValidU),
    .out_ready(outReadyU), .r_out(rOutU), .busy(busyU)
  );

  typedef struct {
    logic [2*W-1:0] r;
    int             lat;
    int             acceptEdge;
  } exp_t;

  exp_t           expQ[$];
  exp_t           popped;
  int             checkCount = 0;
  int             passCount  = 0;
  int             edgeCount  = 0;
  logic           prevValid  = 1'b0;
  logic [2*W-1:0] heldExp    = '0;
  logic           randReady  = 1'b0;

  always @(posedge clk) edgeCount <= edgeCount + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic reportTimeout(input string name);
    checkCount++;
    $display("[TB] FAIL %s: event did not occur within its cycle bound", name);
  endtask

  function automatic logic [2*W-1:0] modelProduct(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm);
    longint pa, pb, p;
    if (sm) begin
      pa = longint'($signed(a));
      pb = longint'($signed(b));
    end else begin
      pa = longint'(a);
      pb = longint'(b);
    end
    p = pa * pb;
    return p[2*W-1:0];
  endfunction

  function automatic int modelLatency(input logic [W-1:0] b, input logic sm);
    int v;
    v = sm ? int'($signed(b)) : int'(b);
    if (v < 0) v = -v;
    return int'(iterCount(64'(v))) + 2;
  endfunction

  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm, output bit accepted);
    int t = 0;
    accepted = 1'b0;
    @(negedge clk);
    aIn = a; bIn = b; signedMode = sm; inValid = 1'b1;
    while (!inReady && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!inReady) begin
      reportTimeout("accept");
      inValid = 1'b0;
      return;
    end
    expQ.push_back('{modelProduct(a, b, sm), modelLatency(b, sm), edgeCount + 1});
    @(posedge clk);
    #1 inValid = 1'b0;
    accepted = 1'b1;
  endtask

  task automatic applyUnsigned(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm);
    int t = 0;
    @(negedge clk);
    aInU = a; bInU = b; signedModeU = sm; inValidU = 1'b1;
    while (!inReadyU && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!inReadyU) begin
      reportTimeout("unsigned-only accept");
      inValidU = 1'b0;
      return;
    end
    @(posedge clk);
    #1 inValidU = 1'b0;
    t = 0;
    @(negedge clk);
    while (!outValidU && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!outValidU) reportTimeout("unsigned-only output");
    else checkOutput("unsigned-only product", 32'(rOutU), 32'(modelProduct(a, b, 1'b0)));
  endtask

  task automatic waitDrain();
    int t = 0;
    while ((expQ.size() != 0 || outValid) && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (expQ.size() != 0 || outValid) reportTimeout("drain");
  endtask

  always @(negedge clk) begin
    if (reset) begin
      prevValid = 1'b0;
    end else begin
      if (outValid && !prevValid) begin
        if (expQ.size() == 0) begin
          checkCount++;
          $display("[TB] FAIL unexpected output: r_out=0x%0h with no operation pending", rOut);
        end else begin
          popped = expQ.pop_front();
          checkOutput("product", 32'(rOut), 32'(popped.r));
          checkOutput("latency", edgeCount - popped.acceptEdge, popped.lat);
          heldExp = popped.r;
        end
      end else if (outValid) begin
        checkOutput("held r_out", 32'(rOut), 32'(heldExp));
      end
      prevValid = outValid;
    end
  end

  always @(negedge clk) begin
    if (randReady) outReady = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit ok;
    int t;
    logic [W-1:0] ra, rb;
    logic [2*W-1:0] heldVal;

    reset = 1'b1; inValid = 1'b0; signedMode = 1'b0; aIn = '0; bIn = '0; outReady = 1'b1;
    inValidU = 1'b0; signedModeU = 1'b0; aInU = '0; bInU = '0; outReadyU = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("reset in_ready", 32'(inReady), 32'(1));
    checkOutput("reset out_valid", 32'(outValid), 32'(0));
    checkOutput("reset r_out", 32'(rOut), 32'(0));
    checkOutput("reset busy", 32'(busy), 32'(0));

    $display("[TB] directed products and early termination");
    applyStimulus(8'd13, 8'd11, 1'b0, ok);
    applyStimulus(8'd255, 8'd255, 1'b0, ok);
    applyStimulus(8'h80, 8'h80, 1'b1, ok);
    applyStimulus(8'h80, 8'h7F, 1'b1, ok);
    applyStimulus(8'd200, 8'd0, 1'b0, ok);
    applyStimulus(8'd7, 8'd1, 1'b0, ok);
    waitDrain();

    $display("[TB] backpressure");
    @(negedge clk);
    outReady = 1'b0;
    applyStimulus(8'd100, 8'hFB, 1'b1, ok);
    heldVal = modelProduct(8'd100, 8'hFB, 1'b1);
    t = 0;
    @(negedge clk);
    while (!outValid && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!outValid) reportTimeout("backpressure output");
    for (int i = 0; i < 5; i++) begin
      inValid = 1'b1;
      aIn = W'($urandom);
      bIn = W'($urandom);
      checkOutput("in_ready while DONE", 32'(inReady), 32'(0));
      checkOutput("out_valid held", 32'(outValid), 32'(1));
      checkOutput("r_out held", 32'(rOut), 32'(heldVal));
      @(negedge clk);
    end
    inValid = 1'b0;
    outReady = 1'b1;
    @(negedge clk);
    checkOutput("idle after handshake", 32'(inReady), 32'(1));
    checkOutput("out_valid dropped", 32'(outValid), 32'(0));
    checkOutput("r_out kept", 32'(rOut), 32'(heldVal));
    applyStimulus(8'd3, 8'd5, 1'b0, ok);
    waitDrain();

    $display("[TB] reset during RUN");
    applyStimulus(8'd99, 8'd200, 1'b0, ok);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    if (ok) void'(expQ.pop_back());
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("abort out_valid", 32'(outValid), 32'(0));
    checkOutput("abort r_out", 32'(rOut), 32'(0));
    checkOutput("abort in_ready", 32'(inReady), 32'(1));
    applyStimulus(8'd2, 8'hFD, 1'b1, ok);
    waitDrain();

    $display("[TB] randomized operations");
    randReady = 1'b1;
    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 3)) : W'($urandom);
      applyStimulus(ra, rb, 1'($urandom_range(0, 1)), ok);
    end
    randReady = 1'b0;
    @(negedge clk);
    outReady = 1'b1;
    waitDrain();

    $display("[TB] signed mode disabled");
    applyUnsigned(8'hFF, 8'h02, 1'b1);
    for (int i = 0; i < 4; i++) begin
      applyUnsigned(W'($urandom), W'($urandom), 1'b1);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/shift_add_multiplier.md
Name: shift_add_multiplier

Overview:
Parametrised, self-sequenced shift-and-add multiplier with its own control FSM. It handles unsigned and two's-complement operands, selected per operation. It terminates early once the remaining multiplier bits are zero, and uses valid/ready handshakes on both input and output. It is the next generation of our sequential multiplier, replacing the externally sequenced sel-driven datapath plus separate controller pair.

Parameters:
WIDTH, 8, operand width in bits (>=2); result is 2*WIDTH bits
SIGNED_EN, 1, 1 = signed_mode input honoured; 0 = signed_mode ignored, always unsigned

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high reset
in_valid  in  1  operands presented
in_ready  out  1  block can accept operands (high only in IDLE)
signed_mode  in  1  1 = treat a_in/b_in as two's complement; sampled with operands
a_in  in  WIDTH  multiplicand
b_in  in  WIDTH  multiplier
out_valid  out  1  r_out holds a completed product
out_ready  in  1  consumer accepts product
r_out  out  2*WIDTH  product; signed or unsigned per the sampled mode
busy  out  1  high in RUN and DONE

Behaviour:
- Reset (synchronous, active-high): state=IDLE; in_ready=1 after the reset edge; out_valid=0; busy=0; r_out=0; all internal registers 0. Reset asserted mid-operation aborts it; no partial result is ever presented.
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid&in_ready, transition to RUN.
  - Load a_reg = zero-extended |a| (2*WIDTH bits) and b_reg = |b| (WIDTH bits).
  - Clear p_reg; set count = WIDTH.
  - Set neg = signed_mode & SIGNED_EN & (a_msb ^ b_msb).
  - Magnitudes are taken only when signed mode is active; otherwise raw values are loaded.
- |x| for the most negative value (e.g. -128) is the unsigned pattern 2^(WIDTH-1). This is legal and needs no extra bit.
- RUN, one iteration per cycle:
  - If b_reg==0 or count==0, go to DONE.
  - Otherwise p_reg += b_reg[0] ? a_reg : 0; a_reg <<= 1; b_reg >>= 1; count -= 1.
- Entering DONE: r_out = neg ? -p_reg : p_reg (2*WIDTH-bit two's complement); out_valid=1.
- DONE: r_out and out_valid are held stable until out_ready. On out_valid&out_ready, go to IDLE, deassert out_valid, and leave r_out holding the last value.
- Latency: iterations = bit length of the multiplier magnitude (0 for b=0, max WIDTH). From the accept edge to the edge that raises out_valid is iterations+2 cycles.
- in_valid during RUN/DONE is ignored (in_ready=0), with no corruption.
- Back-to-back operation: a new accept is possible on the cycle after the DONE handshake, with one IDLE cycle minimum.
- out_ready high before out_valid has no effect.
- The arithmetic cannot overflow: the full 2*WIDTH product is exact in both modes.

Decomposition:
- Package mult_pkg holds:
  - the state enum (IDLE, RUN, DONE, 2-bit encoding);
  - a function for the iteration count, used by the bench.
- One sub-module, shift_add_datapath. It contains the a/b/p/count registers and the add/shift/negate logic, driven by load/step/finish strobes from the FSM in the top level.

Test Plan:
1. WIDTH=8, unsigned: a=13, b=11 accepted -> out_valid exactly 6 cycles after accept (4 iterations + 2); r_out=143.
2. Unsigned a=255, b=255 -> r_out=65025, 10 cycles latency; then signed a=-128, b=-128 -> r_out=16384; a=-128, b=127 -> r_out=0xC080 (-16256).
3. Early termination: a=200, b=0 -> r_out=0 two cycles after accept; a=7, b=1 -> r_out=7 in 3 cycles.
4. Backpressure: hold out_ready=0 for 5 cycles after out_valid -> r_out/out_valid stable and in_valid ignored (in_ready=0). Release -> IDLE next cycle, and a second operation (a=3, b=5, expect 15) is accepted.
5. Reset mid-RUN (a=99, b=200, reset after 3 iterations) -> after the reset edge: out_valid=0, r_out=0, in_ready=1; a new op a=2, b=-3 signed gives r_out=0xFFFA.
6. SIGNED_EN=0 build: signed_mode=1, a=0xFF, b=0x02 -> r_out=510 (unsigned result despite the mode bit).
